fetch_decode_bundle_reg: RTL and testbench
==========================================

Name: fetch_decode_bundle_reg

Overview:
- N-slot successor to the scalar fetch/decode pipeline register for the superscalar front end.
- Holds up to WIDTH fetched instructions (pc, instr, predicted-taken) between fetch and decode.
- Supports partial consumption by decode: unconsumed slots shift to slot 0 and keep program order.
- New fetch bundles are appended when they fit. Supports global hold (cache miss) and flush (redirect).

Parameters:
- WIDTH, 2, number of instruction slots (>=1).
- XLEN, 32, pc/instruction width.
- CW, $clog2(WIDTH+1), width of count fields (derived, not overridable).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- hold  in  1  freeze all state (I/D cache miss); overrides everything except reset.
- flush  in  1  discard all held entries and the incoming bundle.
- in_valid  in  WIDTH  per-slot valid of incoming bundle; must be contiguous from bit 0.
- in_pc  in  WIDTH*XLEN  slot i at bits [i*XLEN +: XLEN].
- in_instr  in  WIDTH*XLEN  same packing.
- in_pred_taken  in  WIDTH  branch predictor bit per slot.
- in_ready  out  1  whole incoming bundle accepted this cycle when high.
- deq_cnt  in  CW  number of slots (from slot 0) decode consumes this cycle.
- out_valid  out  WIDTH  out_valid[i] = (i < count).
- out_pc  out  WIDTH*XLEN  held pcs, slot 0 oldest.
- out_instr  out  WIDTH*XLEN  held instructions.
- out_pred_taken  out  WIDTH  held prediction bits.
- out_count  out  CW  number of valid held entries.

Behaviour:
- Reset (async): count=0; all slot pc/instr/pred_taken=0; so out_valid=0, out_* = 0, in_ready=0 while reset is asserted.
- Outputs are driven directly from registers. Slots at index >= count always read 0.
- Derived values:
  - in_cnt = popcount(in_valid).
  - deq_eff = min(deq_cnt, count): over-request is clamped, never underflows.
  - remain = count - deq_eff.
- in_ready (combinational) = !reset & !hold & !flush & (WIDTH - remain >= in_cnt). It is 1 when in_cnt=0 under the same gating.
- Accept: bundle taken atomically iff in_ready & in_cnt>0. No partial acceptance of a bundle.
- Next state when !hold & !flush:
  - slot j <= old slot (j+deq_eff) for j < remain.
  - slot remain+k <= incoming slot k for k < in_cnt if accepted.
  - Slots >= new count are zeroed.
  - count <= remain + (accepted ? in_cnt : 0).
- Latency: an accepted instruction is visible on out_* the cycle after acceptance. The same-cycle dequeue and enqueue of a full buffer is legal (deq_cnt=WIDTH, in_cnt=WIDTH -> in_ready=1, full throughput).
- flush & !hold: count <= 0, all slots zeroed, in_ready=0, incoming bundle dropped, deq_cnt ignored.
- hold=1: no register changes, flush and deq_cnt ignored, in_ready=0. Upstream keeps flush asserted until hold drops; flush takes effect on the first non-hold edge.
- Non-contiguous in_valid (e.g. 2'b10) is illegal: simulation assertion fires. RTL uses in_cnt packing from slot 0 regardless.
- Reset asserted mid-operation: immediate clear; first edge after deassertion behaves as empty buffer.

Decomposition:
- Shared package fe_pipe_pkg:
  - slot_t packed struct {pc[XLEN], instr[XLEN], pred_taken}.
  - XLEN constant.
  - popcount function.
- One natural sub-module, slot_compactor (combinational). Inputs: current slots, count, deq_eff, incoming slots, in_cnt, accept. Output: next slot array and next count. The top module holds registers, the hold/flush/reset muxing, and the in_ready logic.

Test Plan:
- Reset then fill, WIDTH=2: in_valid=2'b11, pc 0x100/0x104, deq_cnt=0 -> in_ready=1; next cycle out_valid=2'b11, out_pc={0x104,0x100}, out_count=2.
- Partial consume: held {0x100,0x104}, deq_cnt=1, in_valid=2'b01 pc 0x108 -> in_ready=1; next out_pc slot0=0x104, slot1=0x108, count=2.
- Back-pressure: held 2, deq_cnt=0, in_valid=2'b01 -> in_ready=0; state unchanged. Over-request deq_cnt=3 with count=1 -> count becomes 0, no underflow.
- Full throughput: held 2, deq_cnt=2, in_valid=2'b11 pcs 0x200/0x204 -> next out_pc={0x204,0x200}, count=2.
- Hold vs flush: held 2, hold=1 & flush=1 for 3 cycles -> outputs unchanged, in_ready=0. hold drops with flush=1 -> next cycle count=0, all out_* = 0.
- Async reset mid-stream: assert reset between edges with count=2 -> out_valid=0 and out_pc=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/fe_pipe_pkg.sv
// fe_pipe_pkg: shared front-end types and helpers for the fetch/decode pipeline.
package fe_pipe_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            pred_taken;
    } slot_t;

    function automatic int unsigned popcount(input logic [31:0] v);
        popcount = 0;
        for (int i = 0; i < 32; i++) popcount += 32'(v[i]);
    endfunction

endpackage

// File: rtl/fetch_decode_bundle_reg_slot_compactor.sv
// slot_compactor: next-state slot array after partial dequeue and optional bundle append.
module slot_compactor
    import fe_pipe_pkg::*;
#(
    parameter int WIDTH = 2,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  slot_t [WIDTH-1:0] cur,
    input  logic  [CW-1:0]    count,
    input  logic  [CW-1:0]    deq_eff,
    input  slot_t [WIDTH-1:0] in_slots,
    input  logic  [CW-1:0]    in_cnt,
    input  logic              accept,
    output slot_t [WIDTH-1:0] nxt,
    output logic  [CW-1:0]    nxt_count
);

    localparam int IW = WIDTH > 1 ? $clog2(WIDTH) : 1;

    logic [CW-1:0] remain;

    assign remain    = count - deq_eff;
    assign nxt_count = remain + (accept ? in_cnt : '0);

    // Survivors shift down to slot 0; the new bundle lands right behind them.
    for (genvar i = 0; i < WIDTH; i++) begin : g_slot
        assign nxt[i] = CW'(i) < remain ? cur[IW'(i + int'(deq_eff))]
                      : (accept && (CW'(i) - remain < in_cnt)) ? in_slots[IW'(i - int'(remain))]
                      : '0;
    end

endmodule

// File: rtl/fetch_decode_bundle_reg.sv
// fetch_decode_bundle_reg: WIDTH-slot fetch/decode buffer with partial consume,
// atomic bundle append, hold (cache miss) and flush (redirect).
module fetch_decode_bundle_reg
    import fe_pipe_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int XLEN = fe_pipe_pkg::XLEN,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  hold,
    input  logic                  flush,
    input  logic [WIDTH-1:0]      in_valid,
    input  logic [WIDTH*XLEN-1:0] in_pc,
    input  logic [WIDTH*XLEN-1:0] in_instr,
    input  logic [WIDTH-1:0]      in_pred_taken,
    output logic                  in_ready,
    input  logic [CW-1:0]         deq_cnt,
    output logic [WIDTH-1:0]      out_valid,
    output logic [WIDTH*XLEN-1:0] out_pc,
    output logic [WIDTH*XLEN-1:0] out_instr,
    output logic [WIDTH-1:0]      out_pred_taken,
    output logic [CW-1:0]         out_count
);

    if (XLEN != fe_pipe_pkg::XLEN) begin : g_bad_xlen
        $error("XLEN must match fe_pipe_pkg::XLEN");
    end
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("WIDTH must be in 1..32");
    end

    slot_t [WIDTH-1:0] slots, in_slots, nxt;
    logic  [CW-1:0]    count, in_cnt, deq_eff, remain, nxt_count;
    logic              accept;

    assign in_cnt   = CW'(popcount(32'(in_valid)));
    assign deq_eff  = deq_cnt < count ? deq_cnt : count;
    assign remain   = count - deq_eff;
    assign in_ready = !reset && !hold && !flush && (CW'(WIDTH) - remain >= in_cnt);
    assign accept   = in_ready && in_cnt != '0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_io
        assign in_slots[i] = '{pc: in_pc[i*XLEN +: XLEN], instr: in_instr[i*XLEN +: XLEN],
                               pred_taken: in_pred_taken[i]};
        assign out_pc[i*XLEN +: XLEN]    = slots[i].pc;
        assign out_instr[i*XLEN +: XLEN] = slots[i].instr;
        assign out_pred_taken[i]         = slots[i].pred_taken;
        assign out_valid[i]              = CW'(i) < count;
    end

    assign out_count = count;

    slot_compactor #(.WIDTH(WIDTH)) u_compactor (
        .cur       (slots),
        .count     (count),
        .deq_eff   (deq_eff),
        .in_slots  (in_slots),
        .in_cnt    (in_cnt),
        .accept    (accept),
        .nxt       (nxt),
        .nxt_count (nxt_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slots <= '0;
            count <= '0;
        end else if (!hold) begin
            slots <= flush ? '0 : nxt;
            count <= flush ? '0 : nxt_count;
        end
    end

    // Valid bits of an incoming bundle must be packed from slot 0.
    assert property (@(posedge clk) disable iff (reset)
        (in_valid & (in_valid + WIDTH'(1))) == '0);

endmodule

// File: tb/tb_fetch_decode_bundle_reg.sv
// tb_fetch_decode_bundle_reg: directed vectors with a queue scoreboard checked
// by an independent negedge monitor.
module tb_fetch_decode_bundle_reg;

    logic        clk = 0, reset = 1, hold = 0, flush = 0;
    logic [1:0]  in_valid = 0, in_pred_taken = 0, deq_cnt = 0;
    logic [63:0] in_pc = 0, in_instr = 0;
    logic        in_ready;
    logic [1:0]  out_valid, out_pred_taken, out_count;
    logic [63:0] out_pc, out_instr;

    typedef struct {
        logic        rdy;
        logic [1:0]  cnt;
        logic [31:0] pc0, pc1;
        logic [1:0]  pred;
    } exp_t;

    exp_t q[$];
    int total = 0, fails = 0;

    fetch_decode_bundle_reg #(.WIDTH(2), .XLEN(32)) dut (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
        .in_pred_taken(in_pred_taken), .in_ready(in_ready), .deq_cnt(deq_cnt),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
        .out_pred_taken(out_pred_taken), .out_count(out_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ins(input logic [31:0] p);
        return p == 0 ? 32'h0 : p + 32'h1300_0000;
    endfunction

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", n, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("in_ready", 64'(in_ready), 64'(e.rdy));
            chk("out_count", 64'(out_count), 64'(e.cnt));
            chk("out_valid", 64'(out_valid), 64'({e.cnt >= 2'd2, e.cnt >= 2'd1}));
            chk("out_pc", out_pc, {e.pc1, e.pc0});
            chk("out_instr", out_instr, {ins(e.pc1), ins(e.pc0)});
            chk("out_pred", 64'(out_pred_taken), 64'(e.pred));
        end
    end

    task automatic drive(input logic r, input logic h, input logic f, input logic [1:0] iv,
                         input logic [31:0] p0, input logic [31:0] p1, input logic [1:0] pr,
                         input logic [1:0] dq, input logic erdy, input logic [1:0] ecnt,
                         input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] epr);
        @(posedge clk);
        #1;
        reset = r; hold = h; flush = f; in_valid = iv; deq_cnt = dq;
        in_pc = {p1, p0}; in_instr = {ins(p1), ins(p0)}; in_pred_taken = pr;
        q.push_back('{erdy, ecnt, e0, e1, epr});
    endtask

    initial begin
        //     r  h  f  iv     p0     p1     pr     dq     rdy  cnt    e0     e1     epr
        drive(1, 0, 0, 2'b11, 'h100, 'h104, 2'b10, 2'd0, 0, 2'd0, 'h0,   'h0,   2'b00);
        drive(0, 0, 0, 2'b11, 'h100, 'h104, 2'b10, 2'd0, 1, 2'd0, 'h0,   'h0,   2'b00);
        drive(0, 0, 0, 2'b01, 'h108, 'h0,   2'b00, 2'd1, 1, 2'd2, 'h100, 'h104, 2'b10);
        drive(0, 0, 0, 2'b01, 'h10c, 'h0,   2'b00, 2'd0, 0, 2'd2, 'h104, 'h108, 2'b01);
        drive(0, 0, 0, 2'b00, 'h0,   'h0,   2'b00, 2'd1, 1, 2'd2, 'h104, 'h108, 2'b01);
        drive(0, 0, 0, 2'b00, 'h0,   'h0,   2'b00, 2'd3, 1, 2'd1, 'h108, 'h0,   2'b00);
        drive(0, 0, 0, 2'b11, 'h200, 'h204, 2'b11, 2'd0, 1, 2'd0, 'h0,   'h0,   2'b00);
        drive(0, 0, 0, 2'b11, 'h300, 'h304, 2'b00, 2'd2, 1, 2'd2, 'h200, 'h204, 2'b11);
        drive(0, 0, 0, 2'b01, 'h308, 'h0,   2'b01, 2'd2, 1, 2'd2, 'h300, 'h304, 2'b00);
        drive(0, 0, 0, 2'b01, 'h30c, 'h0,   2'b01, 2'd0, 1, 2'd1, 'h308, 'h0,   2'b01);
        for (int i = 0; i < 3; i++)
            drive(0, 1, 1, 2'b11, 'h400, 'h404, 2'b11, 2'd2, 0, 2'd2, 'h308, 'h30c, 2'b11);
        drive(0, 0, 1, 2'b01, 'h400, 'h0,   2'b01, 2'd0, 0, 2'd2, 'h308, 'h30c, 2'b11);
        drive(0, 0, 0, 2'b11, 'h500, 'h504, 2'b10, 2'd1, 1, 2'd0, 'h0,   'h0,   2'b00);
        drive(0, 0, 0, 2'b00, 'h0,   'h0,   2'b00, 2'd0, 1, 2'd2, 'h500, 'h504, 2'b10);
        drive(1, 0, 0, 2'b00, 'h0,   'h0,   2'b00, 2'd0, 0, 2'd0, 'h0,   'h0,   2'b00);
        drive(0, 0, 0, 2'b01, 'h600, 'h0,   2'b01, 2'd2, 1, 2'd0, 'h0,   'h0,   2'b00);
        drive(0, 0, 0, 2'b00, 'h0,   'h0,   2'b00, 2'd1, 1, 2'd1, 'h600, 'h0,   2'b01);
        drive(0, 0, 0, 2'b00, 'h0,   'h0,   2'b00, 2'd0, 1, 2'd0, 'h0,   'h0,   2'b00);
        for (int k = 0; k < 10 && q.size() != 0; k++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            total++;
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
